packet_checker: RTL

Receive-side counterpart of the traffic generator's frame builder. Consumes AXI-Stream Ethernet frames and extracts the header: destination MAC, source MAC, ethertype and the fill byte. Checks that every payload byte equals the fill byte, measures frame length from `tkeep`, and writes one result record per frame into a downstream result FIFO. It sits on the RX loopback/capture path and feeds software-visible statistics.

---
 rtl/pkt_pkg.sv | 30 +++
 rtl/keep_popcount.sv | 29 ++
 rtl/packet_checker.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pkt_pkg.sv
// Shared definitions for the frame builder / packet checker pair:
// header layout, size limit, error flag positions and FSM encoding.
package pkt_pkg;

  localparam int DMAC_LSB    = 0;
  localparam int SMAC_LSB    = 48;
  localparam int ETYPE_LSB   = 96;
  localparam int PAYLOAD_LSB = 112;
  localparam int HDR_BYTES   = 14;

  localparam int MAX_FRAME = 2047;

  localparam int ERR_PAYLOAD  = 0;
  localparam int ERR_KEEP     = 1;
  localparam int ERR_OVERSIZE = 2;
  localparam int ERR_RUNT     = 3;

  typedef enum logic {
    HEADER = 1'b0,
    BODY   = 1'b1
  } state_t;

  // 12-bit add that sticks at all-ones instead of wrapping
  function automatic logic [11:0] sat_add12(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[12] ? 12'hFFF : sum[11:0];
  endfunction

endpackage

// File: rtl/keep_popcount.sv
// Counts the set bits of a tkeep vector and reports whether the set bits
// form one run starting at bit 0 (the only legal keep shape).
module keep_popcount #(
  parameter int KEEP_WIDTH  = 64,
  parameter int COUNT_WIDTH = $clog2(KEEP_WIDTH + 1)
) (
  input  logic [KEEP_WIDTH-1:0]  keep,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   contiguous
);

  logic [KEEP_WIDTH-1:0] keep_plus_one;

  // Sum of the keep bits
  always_comb begin
    count = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      count = count + COUNT_WIDTH'(keep[i]);
    end
  end

  // A run of ones from bit 0 turns into a single carry when incremented,
  // so it shares no set bit with its increment
  always_comb begin
    keep_plus_one = keep + KEEP_WIDTH'(1);
    contiguous    = ((keep & keep_plus_one) == '0);
  end

endmodule

// File: rtl/packet_checker.sv
// Receive-side frame checker: parses the header of each AXI-Stream frame,
// verifies the payload against the fill byte, measures the frame length
// and emits one result record per frame through a single hold register.
module packet_checker
  import pkt_pkg::*;
#(
  parameter int DATA_WIDTH = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  input  logic                    result_wr_full,
  output logic                    result_wr_en,
  output logic [10:0]             r_size,
  output logic [47:0]             r_d_mac,
  output logic [47:0]             r_s_mac,
  output logic [15:0]             r_ethertype,
  output logic [7:0]              r_payload,
  output logic [3:0]              r_err,
  output logic [31:0]             frame_count,
  output logic [31:0]             error_count
);

  localparam int N             = DATA_WIDTH / 8;
  localparam int CW            = $clog2(N + 1);
  localparam int FIRST_CHECKED = HDR_BYTES + 1;

  state_t state, state_next;

  logic [CW-1:0] beat_count;
  logic          keep_contig;
  logic [11:0]   beat_count_12;

  logic          hold_valid;
  logic          accept;
  logic          finalize;
  logic          is_header;

  logic [47:0]   frame_d_mac;
  logic [47:0]   frame_s_mac;
  logic [15:0]   frame_etype;
  logic [7:0]    frame_fill;
  logic [11:0]   acc;
  logic [3:0]    err_sticky;

  logic [7:0]    beat_fill;
  logic [7:0]    fill_ref;
  logic          byte_mismatch;
  logic [11:0]   count_next;
  logic [3:0]    err_beat;
  logic [3:0]    err_next;
  logic [10:0]   size_next;
  logic [47:0]   cur_d_mac;
  logic [47:0]   cur_s_mac;
  logic [15:0]   cur_etype;

  keep_popcount #(
    .KEEP_WIDTH (N),
    .COUNT_WIDTH(CW)
  ) u_keep_popcount (
    .keep      (s_axis_tkeep),
    .count     (beat_count),
    .contiguous(keep_contig)
  );

  assign s_axis_tready = !(hold_valid && result_wr_full);
  assign result_wr_en  = hold_valid && !result_wr_full;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign finalize      = accept && s_axis_tlast;
  assign is_header     = (state == HEADER);
  assign beat_count_12 = 12'(beat_count);
  assign beat_fill     = s_axis_tdata[PAYLOAD_LSB +: 8];
  assign fill_ref      = is_header ? beat_fill : frame_fill;

  // Header fields for the record: straight from the beat on a one-beat
  // frame, otherwise from what was captured on the first beat
  always_comb begin
    cur_d_mac = is_header ? s_axis_tdata[DMAC_LSB +: 48]  : frame_d_mac;
    cur_s_mac = is_header ? s_axis_tdata[SMAC_LSB +: 48]  : frame_s_mac;
    cur_etype = is_header ? s_axis_tdata[ETYPE_LSB +: 16] : frame_etype;
  end

  // Flag any kept byte that differs from the fill byte; on the first beat
  // the header and the fill byte itself are skipped
  always_comb begin
    byte_mismatch = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (s_axis_tkeep[i] && (!is_header || i >= FIRST_CHECKED) &&
          s_axis_tdata[8*i +: 8] != fill_ref) begin
        byte_mismatch = 1'b1;
      end
    end
  end

  // Running length and error flags including the current beat
  always_comb begin
    count_next             = is_header ? beat_count_12 : sat_add12(acc, beat_count_12);
    err_beat               = '0;
    err_beat[ERR_PAYLOAD]  = byte_mismatch;
    err_beat[ERR_KEEP]     = (!s_axis_tlast && !(&s_axis_tkeep)) || !keep_contig;
    err_beat[ERR_OVERSIZE] = (count_next > 12'(MAX_FRAME));
    err_beat[ERR_RUNT]     = is_header && s_axis_tlast && (beat_count_12 < 12'(FIRST_CHECKED));
    err_next               = is_header ? err_beat : (err_sticky | err_beat);
    size_next              = (count_next > 12'(MAX_FRAME)) ? 11'(MAX_FRAME) : count_next[10:0];
  end

  // Next-state logic: a non-last beat leads into the body, tlast returns to header
  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = s_axis_tlast ? HEADER : BODY;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HEADER;
    end else begin
      state <= state_next;
    end
  end

  // Per-frame tracking: header capture, length accumulator and sticky errors
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_d_mac <= '0;
      frame_s_mac <= '0;
      frame_etype <= '0;
      frame_fill  <= '0;
      acc         <= '0;
      err_sticky  <= '0;
    end else if (accept) begin
      acc        <= count_next;
      err_sticky <= err_next;
      if (is_header) begin
        frame_d_mac <= s_axis_tdata[DMAC_LSB +: 48];
        frame_s_mac <= s_axis_tdata[SMAC_LSB +: 48];
        frame_etype <= s_axis_tdata[ETYPE_LSB +: 16];
        frame_fill  <= beat_fill;
      end
    end
  end

  // Result hold register and statistics; a finalize in the same cycle as
  // a write reloads the register instead of emptying it
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid  <= 1'b0;
      r_size      <= '0;
      r_d_mac     <= '0;
      r_s_mac     <= '0;
      r_ethertype <= '0;
      r_payload   <= '0;
      r_err       <= '0;
      frame_count <= '0;
      error_count <= '0;
    end else if (finalize) begin
      hold_valid  <= 1'b1;
      r_size      <= size_next;
      r_d_mac     <= cur_d_mac;
      r_s_mac     <= cur_s_mac;
      r_ethertype <= cur_etype;
      r_payload   <= fill_ref;
      r_err       <= err_next;
      frame_count <= frame_count + 32'd1;
      if (err_next != '0) begin
        error_count <= error_count + 32'd1;
      end
    end else if (result_wr_en) begin
      hold_valid <= 1'b0;
    end
  end

endmodule
